// File: rtl/tm_shiftreg_pkg.sv
// tm_shiftreg_pkg: shared state encoding and parameter helpers for the
// TM configuration shift-register writer.
package tm_shiftreg_pkg;

    // One-hot FSM state encoding
    localparam int unsigned ST_W = 6;

    localparam logic [ST_W-1:0] ST_IDLE  = 6'b000001;
    localparam logic [ST_W-1:0] ST_SETUP = 6'b000010;
    localparam logic [ST_W-1:0] ST_HIGH  = 6'b000100;
    localparam logic [ST_W-1:0] ST_LOW   = 6'b001000;
    localparam logic [ST_W-1:0] ST_LOAD  = 6'b010000;
    localparam logic [ST_W-1:0] ST_DONE  = 6'b100000;

    // Smallest counter width w with 2^w > data_width, so the bit counter
    // can hold the terminal value data_width itself.
    function automatic int unsigned min_cnt_width(input int unsigned data_width);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(data_width)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tm_phase_timer.sv
// tm_phase_timer: times one sclk phase of H = h_m1+1 clk_in cycles.
// Reloaded with h_m1 on every state change; phase_end marks the last
// cycle of the current phase.
module tm_phase_timer #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] h_m1,
    output logic                 phase_end
);

    logic [DIV_WIDTH-1:0] cnt;

    // Down-counter: reload on restart, otherwise count down and hold at zero
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= h_m1;
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_WIDTH'(1);
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/tm_shiftreg_writer.sv
// tm_shiftreg_writer: serialises a DATA_WIDTH configuration word into the
// TM chip shift register (MSB first on sdi, sclk idle low), captures the
// bits returned on sdo into data_rb, then pulses sload to latch the word.
module tm_shiftreg_writer
    import tm_shiftreg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 170,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  sdo,
    output logic                  sclk,
    output logic                  sdi,
    output logic                  sload,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_rb
);

    if (CNT_WIDTH < min_cnt_width(DATA_WIDTH)) begin : g_bad_cnt_width
        $error("tm_shiftreg_writer: CNT_WIDTH too small to count DATA_WIDTH bits");
    end

    if (DATA_WIDTH < 2) begin : g_bad_data_width
        $error("tm_shiftreg_writer: DATA_WIDTH must be at least 2");
    end

    logic [ST_W-1:0]       state;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  h_m1;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic                  accept;
    logic                  timed;
    logic                  restart;
    logic                  phase_end;

    // Start acceptance, timer reload and reload value selection
    always_comb begin
        accept  = (state == ST_IDLE) && start;
        timed   = (state == ST_SETUP) || (state == ST_HIGH) ||
                  (state == ST_LOW)   || (state == ST_LOAD);
        restart = accept || (timed && phase_end);
        // div_q is not yet loaded on the accepting cycle, so take div directly
        h_m1    = (state == ST_IDLE) ? div : div_q;
    end

    tm_phase_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_phase_timer (
        .clk_in    (clk_in),
        .rst       (rst),
        .restart   (restart),
        .h_m1      (h_m1),
        .phase_end (phase_end)
    );

    // sdi is the MSB flop of the transmit register; zeros shifted in at the
    // LSB make sdi drop to 0 once the last bit has gone out.
    assign sdi = tx_sr[DATA_WIDTH-1];

    // Transmit/receive shift registers, latched divider and bit counter
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            div_q   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            tx_sr   <= data_in;
            rx_sr   <= '0;
            div_q   <= div;
            bit_cnt <= '0;
        end else if ((state == ST_HIGH) && phase_end) begin
            tx_sr   <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            rx_sr   <= {rx_sr[DATA_WIDTH-2:0], sdo};
            bit_cnt <= bit_cnt + CNT_WIDTH'(1);
        end
    end

    // Transfer sequencing and registered chip/status outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sclk    <= 1'b0;
            sload   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            data_rb <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SETUP;
                        busy  <= 1'b1;
                        sclk  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        state <= ST_HIGH;
                        sclk  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        state <= ST_LOW;
                        sclk  <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        if (bit_cnt == CNT_WIDTH'(DATA_WIDTH)) begin
                            state <= ST_LOAD;
                            sload <= 1'b1;
                        end else begin
                            state <= ST_HIGH;
                            sclk  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (phase_end) begin
                        state   <= ST_DONE;
                        sload   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        data_rb <= rx_sr;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    sclk  <= 1'b0;
                    sload <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
